// File: rtl/ro_pair_cmp.sv
// ro_pair_cmp: compares the rising-edge counts of two ring oscillators
// over a fixed gate window and produces one PUF response bit.
// Both RO inputs are synchronised into clk, their rising edges are counted
// during the gate window, and the two counts are compared. A start/done
// handshake triggers a measurement.
// Optional feature macro: RO_RAW_CNT_EN adds the cnt_a/cnt_b readout ports.
module ro_pair_cmp #(
  parameter int WINDOW_CYCLES = 4096,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             busy,
  output logic             done,
  output logic             resp,
  output logic             tie
`ifdef RO_RAW_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int FL_W  = $clog2(SYNC_STAGES + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(SYNC_STAGES);
  localparam logic [FL_W-1:0]  FL_ONE   = FL_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_COUNT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [WIN_W-1:0] win_cnt_reg;
  logic [FL_W-1:0]  flush_cnt_reg;
  logic             resp_reg;
  logic             tie_reg;

  logic [1:0]       ro_in;
  logic [1:0]       edge_det;
  logic [CNT_W-1:0] cnt_val [2];
  logic             clear_cnt;

  assign ro_in     = {ro_b, ro_a};
  // Accepting a start is the single point where a new measurement begins.
  assign clear_cnt = (state_reg == S_IDLE) && start;

  // Per-oscillator channel: synchroniser, rising-edge detector, saturating counter.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [SYNC_STAGES-1:0] sync_reg;
    logic             prev_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Shift the asynchronous RO level through the synchroniser, then keep
    // one extra flop of history for edge detection.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_reg <= '0;
        prev_reg <= 1'b0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], ro_in[gi]};
        prev_reg <= sync_reg[SYNC_STAGES-1];
      end
    end

    assign edge_det[gi] = sync_reg[SYNC_STAGES-1] & ~prev_reg;

    // Count synced rising edges only inside the gate window; stick at max.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (clear_cnt) begin
        cnt_reg <= '0;
      end else if ((state_reg == S_COUNT) && edge_det[gi] && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end

    assign cnt_val[gi] = cnt_reg;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake outputs decoded from the current state.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (flush_cnt_reg == FL_LAST) begin
          state_next = S_COUNT;
        end
      end
      S_COUNT: begin
        busy = 1'b1;
        if (win_cnt_reg == WIN_LAST) begin
          state_next = S_COMPARE;
        end
      end
      S_COMPARE: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Flush/window timers and the registered comparison result.
  // The window counter is one bit wider than strictly needed so the final
  // increment past WINDOW_CYCLES-1 never wraps into a misleading value.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_reg   <= '0;
      flush_cnt_reg <= '0;
      resp_reg      <= 1'b0;
      tie_reg       <= 1'b0;
    end else if (clear_cnt) begin
      win_cnt_reg   <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (state_reg == S_FLUSH) begin
        flush_cnt_reg <= flush_cnt_reg + FL_ONE;
      end
      if (state_reg == S_COUNT) begin
        win_cnt_reg <= win_cnt_reg + WIN_ONE;
      end
      if (state_reg == S_COMPARE) begin
        resp_reg <= (cnt_val[0] > cnt_val[1]);
        tie_reg  <= (cnt_val[0] == cnt_val[1]);
      end
    end
  end

  assign resp = resp_reg;
  assign tie  = tie_reg;

`ifdef RO_RAW_CNT_EN
  logic [CNT_W-1:0] cnt_a_reg;
  logic [CNT_W-1:0] cnt_b_reg;

  // Raw counts captured together with resp/tie for characterisation readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_reg <= '0;
      cnt_b_reg <= '0;
    end else if (state_reg == S_COMPARE) begin
      cnt_a_reg <= cnt_val[0];
      cnt_b_reg <= cnt_val[1];
    end
  end

  assign cnt_a = cnt_a_reg;
  assign cnt_b = cnt_b_reg;
`endif

endmodule

// File: doc/ro_pair_cmp.md
Name: ro_pair_cmp

Overview:
Downstream consumer of two ring-oscillator outputs in the weak RO-PUF array. It synchronises both free-running RO signals into the system clock domain, counts rising edges of each over a fixed gate window, and compares the counts to produce one PUF response bit. A top-level challenge sequencer triggers it via a start/done handshake.

Parameters:
WINDOW_CYCLES, 4096, length of the count gate in clk cycles; must be at least 1.
CNT_W, 16, edge-counter width in bits; must be at least 1.
SYNC_STAGES, 2, synchroniser depth per RO input; must be at least 2.

Ports:
clk  input  1  system clock; single clock domain for all state.
rst  input  1  synchronous, active-high reset.
start  input  1  request a measurement; sampled only in IDLE.
ro_a  input  1  asynchronous RO output, first oscillator of the pair.
ro_b  input  1  asynchronous RO output, second oscillator of the pair.
busy  output  1  high from the cycle after start is accepted until done is asserted.
done  output  1  one-cycle pulse when resp/tie are valid.
resp  output  1  1 if count_a > count_b, else 0.
tie  output  1  1 if count_a == count_b.

Behaviour:
- Reset (rst=1 at a clk edge): FSM to IDLE, all counters 0, busy=0, done=0, resp=0, tie=0. Synchroniser flops cleared. Reset mid-measurement aborts it; no done pulse.
- Synchroniser: SYNC_STAGES flops per input (dont_touch/ASYNC_REG attributes), then one edge-detect flop. An edge is a synced 0->1 transition. Sampling is by clk, so meaningful counts require RO frequency below fclk/2 (divide upstream if needed).
- FSM states: IDLE, FLUSH, COUNT, COMPARE, DONE.
  - IDLE -> FLUSH when start=1. Entering FLUSH clears both counters and the window counter.
  - FLUSH lasts SYNC_STAGES+1 cycles and counts no edges, draining stale synchroniser state.
  - COUNT lasts exactly WINDOW_CYCLES cycles. In each COUNT cycle, each counter increments by 1 if its edge is detected.
  - COMPARE lasts 1 cycle and registers resp/tie.
  - DONE lasts 1 cycle with done=1, busy=0, then returns to IDLE.
- Latency: if start is sampled in cycle t, done=1 in cycle t+SYNC_STAGES+WINDOW_CYCLES+3. Defaults give t+4101.
- Counters saturate at 2^CNT_W-1 and never wrap. If both counters saturate, tie=1 and resp=0.
- On equal counts: tie=1, resp=0. resp/tie hold their values until the next COMPARE or reset.
- start while busy or in DONE is ignored and not queued. start held high in IDLE after DONE starts a new measurement.
- Window counter width is clog2(WINDOW_CYCLES+1).

Optional Feature:
RO_RAW_CNT_EN: when defined, adds outputs cnt_a and cnt_b (each CNT_W bits). They are registered in COMPARE alongside resp/tie, are 0 after reset, and hold until the next COMPARE. Used for reliability/characterisation readout. When undefined, these ports and their registers are absent and all other behaviour is identical.

Test Plan:
Config: WINDOW_CYCLES=16, SYNC_STAGES=2, CNT_W=16 unless stated.
1. ro_a toggles every clk (8 edges/window), ro_b toggles every 2 clks (4 edges); start at cycle t -> done pulse at t+21, resp=1, tie=0, cnt_a=8, cnt_b=4 (RO_RAW_CNT_EN).
2. Test 1 with the ro_a and ro_b stimulus swapped -> resp=0, tie=0, cnt_a=4, cnt_b=8.
3. Both ROs toggle every 2 clks -> resp=0, tie=1, counts 4/4. ro_a held constant 0 -> count_a=0, resp=0, tie=0.
4. start pulsed again at t+5 and t+21 while busy/DONE -> ignored; exactly one done pulse; busy falls at t+21.
5. rst=1 asserted at t+10 (during COUNT) -> next cycle busy=0, resp=0, tie=0, no done pulse; a fresh start then completes normally.
6. CNT_W=3, both ROs toggle every clk (8 edges) -> both saturate at 7, tie=1, resp=0. Then ro_b toggles every 2 clks (4 edges) -> resp=1, count_a=7.
